// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter for the write port of an async FIFO. Multi-beat messages hold the grant
// until LAST. Each beat is tagged with its source index, and a burst limit catches a missing LAST.
module async_fifo_wr_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [NUM_REQ-1:0]       REQ_LAST,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]       REQ_READY,
    input  logic                     FIFO_WR_RDY,
    output logic                     FIFO_WR_EN,
    output logic [WIDTH+ID_W-1:0]    FIFO_WR_DATA,
    output logic [ID_W-1:0]          GRANT_ID,
    output logic                     BUSY,
    output logic                     ERR_OVERRUN
);
    localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_reg, state_next;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  grant_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic             err_reg;

    logic [WIDTH-1:0] req_data_arr [NUM_REQ];
    logic [ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]  sel;
    logic             xfer;
    logic             overrun_hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_data_arr[gi] = REQ_DATA[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Walk candidates from farthest to nearest so the nearest valid one after rr_ptr wins.
    always_comb begin
        scan_idx = rr_ptr_reg;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int cand;
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (REQ_VALID[cand]) begin
                scan_idx = ID_W'(cand);
            end
        end
    end

    assign sel         = (state_reg == LOCKED) ? grant_reg : scan_idx;
    assign xfer        = REQ_VALID[sel] & FIFO_WR_RDY & ~RST;
    assign overrun_hit = (MAX_BURST != 0) && (beat_cnt_reg == BURST_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (xfer && !REQ_LAST[sel]) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer && (REQ_LAST[sel] || overrun_hit)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = '0;
        if (xfer) begin
            REQ_READY[sel] = 1'b1;
        end
        FIFO_WR_EN   = xfer;
        FIFO_WR_DATA = {sel, req_data_arr[sel]};
        GRANT_ID     = grant_reg;
        BUSY         = (state_reg == LOCKED);
        ERR_OVERRUN  = err_reg;
    end

    // The pointer moves only on the first beat, so a stalled requester keeps its turn.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr_reg   <= ID_W'(NUM_REQ - 1);
            grant_reg    <= '0;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else if (xfer) begin
            if (state_reg == IDLE) begin
                rr_ptr_reg   <= sel;
                grant_reg    <= sel;
                beat_cnt_reg <= REQ_LAST[sel] ? CNT_W'(0) : CNT_W'(1);
            end else if (REQ_LAST[sel]) begin
                beat_cnt_reg <= '0;
            end else if (overrun_hit) begin
                beat_cnt_reg <= '0;
                err_reg      <= 1'b1;
            end else if (beat_cnt_reg != '1) begin
                beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench for async_fifo_wr_arbiter: a vector table, directed corner sequences and
// random traffic, all compared against a message-level reference model.
module tb_async_fifo_wr_arbiter;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int MB  = 4;
    localparam int IDW = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic [N-1:0]     REQ_VALID;
    logic [N-1:0]     REQ_LAST;
    logic [N*W-1:0]   REQ_DATA;
    logic [N-1:0]     REQ_READY;
    logic             FIFO_WR_RDY;
    logic             FIFO_WR_EN;
    logic [W+IDW-1:0] FIFO_WR_DATA;
    logic [IDW-1:0]   GRANT_ID;
    logic             BUSY;
    logic             ERR_OVERRUN;

    logic [W-1:0] pay [N];

    always #5 CLK = ~CLK;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign REQ_DATA[gi*W +: W] = pay[gi];
        end
    endgenerate

    async_fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST), .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY), .FIFO_WR_RDY(FIFO_WR_RDY), .FIFO_WR_EN(FIFO_WR_EN),
        .FIFO_WR_DATA(FIFO_WR_DATA), .GRANT_ID(GRANT_ID), .BUSY(BUSY), .ERR_OVERRUN(ERR_OVERRUN)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, whose turn is next, beats in current message.
    bit m_locked    = 1'b0;
    int m_owner     = 0;
    int m_last_win  = N - 1;
    int m_beats     = 0;
    bit m_err       = 1'b0;
    bit regs_known  = 1'b0;
    int acc_idx     = -1;

    // DUT values sampled by the most recent cycle, for table and directed checks.
    logic           s_en;
    logic [IDW-1:0] s_id;
    logic           s_busy;
    logic [IDW-1:0] s_grant;
    logic           s_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v);
        if (m_locked) return m_owner;
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last_win + k) % N]) return (m_last_win + k) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                         input logic s, output int g_o, output bit x_o);
        int g;
        bit x;
        logic [W+IDW-1:0] exp_data;
        @(negedge CLK);
        if (acc_idx >= 0) pay[acc_idx] = W'($urandom);
        acc_idx     = -1;
        REQ_VALID   = v;
        REQ_LAST    = l;
        FIFO_WR_RDY = r;
        RST         = s;
        #1;
        g = winner(v);
        x = (g >= 0) && v[g] && r && !s;
        s_en    = FIFO_WR_EN;
        s_id    = FIFO_WR_DATA[W+IDW-1:W];
        s_busy  = BUSY;
        s_grant = GRANT_ID;
        s_err   = ERR_OVERRUN;
        chk("wr_en", 32'(FIFO_WR_EN), 32'(x));
        chk("req_ready", 32'(REQ_READY), x ? (32'd1 << g) : 32'd0);
        if (g >= 0 && !s) begin
            exp_data = {IDW'(g), pay[g]};
            chk("wr_data", 32'(FIFO_WR_DATA), 32'(exp_data));
        end
        if (regs_known) begin
            chk("busy", 32'(BUSY), 32'(m_locked));
            chk("grant_id", 32'(GRANT_ID), 32'(m_owner));
            chk("err_overrun", 32'(ERR_OVERRUN), 32'(m_err));
        end
        @(posedge CLK);
        if (s) begin
            m_locked = 0; m_owner = 0; m_last_win = N - 1; m_beats = 0; m_err = 0;
            regs_known = 1'b1;
        end else if (x) begin
            acc_idx = g;
            if (!m_locked) begin
                m_last_win = g;
                m_owner    = g;
                m_beats    = 1;
                m_locked   = !l[g];
            end else begin
                m_beats++;
                if (l[g]) begin
                    m_locked = 0;
                end else if (m_beats == MB) begin
                    m_locked = 0;
                    m_err    = 1;
                end
            end
        end
        g_o = g;
        x_o = x;
    endtask

    typedef struct {
        logic [N-1:0]   valid;
        logic [N-1:0]   last;
        logic           rdy;
        logic           en;
        logic [IDW-1:0] id;
        logic           busy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int g;
        bit x;
        logic [N-1:0] v, l;
        logic r, s;

        for (int i = 0; i < N; i++) pay[i] = W'($urandom);
        REQ_VALID = '0; REQ_LAST = '0; FIFO_WR_RDY = 1'b0; RST = 1'b1;

        // Round robin over all-single-beat traffic, then a locked 3-beat message, then stalls.
        tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 1'b0});
        tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b0});
        tbl.push_back('{4'h7, 4'h5, 1'b1, 1'b1, 2'd1, 1'b0});
        tbl.push_back('{4'h7, 4'h5, 1'b1, 1'b1, 2'd1, 1'b1});
        tbl.push_back('{4'h7, 4'h7, 1'b1, 1'b1, 2'd1, 1'b1});
        tbl.push_back('{4'h5, 4'h5, 1'b1, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{4'h1, 4'h1, 1'b1, 1'b1, 2'd0, 1'b0});
        tbl.push_back('{4'h8, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0});
        tbl.push_back('{4'h8, 4'h0, 1'b0, 1'b0, 2'd3, 1'b1});
        tbl.push_back('{4'h8, 4'h0, 1'b0, 1'b0, 2'd3, 1'b1});
        tbl.push_back('{4'h8, 4'h8, 1'b1, 1'b1, 2'd3, 1'b1});

        cycle('0, '0, 1'b1, 1'b1, g, x);
        cycle(4'hF, 4'hF, 1'b1, 1'b1, g, x);

        foreach (tbl[i]) begin
            cycle(tbl[i].valid, tbl[i].last, tbl[i].rdy, 1'b0, g, x);
            chk($sformatf("tbl%0d_en", i), 32'(s_en), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_id", i), 32'(s_id), 32'(tbl[i].id));
            chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
        end

        // Overrun: req2 never sends LAST; forced release after 4 beats, req0 goes next.
        cycle(4'h4, 4'h0, 1'b1, 1'b0, g, x);
        for (int i = 0; i < 3; i++) cycle(4'h5, 4'h1, 1'b1, 1'b0, g, x);
        chk("ovr_owner", 32'(s_id), 32'd2);
        cycle(4'h1, 4'h1, 1'b1, 1'b0, g, x);
        chk("ovr_err", 32'(s_err), 32'd1);
        chk("ovr_next_id", 32'(s_id), 32'd0);
        chk("ovr_next_en", 32'(s_en), 32'd1);

        // Reset in the middle of a 5-beat message from req1.
        cycle(4'h2, 4'h0, 1'b1, 1'b0, g, x);
        cycle(4'h2, 4'h0, 1'b1, 1'b0, g, x);
        cycle(4'h2, 4'h0, 1'b1, 1'b1, g, x);
        chk("rst_en", 32'(s_en), 32'd0);
        cycle(4'hF, 4'hF, 1'b1, 1'b0, g, x);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_grant", 32'(s_grant), 32'd0);
        chk("rst_err", 32'(s_err), 32'd0);
        chk("rst_first_id", 32'(s_id), 32'd0);

        // Lone requester 3 streams single-beat messages back to back.
        for (int i = 0; i < 5; i++) begin
            cycle(4'h8, 4'h8, 1'b1, 1'b0, g, x);
            chk("solo_en", 32'(s_en), 32'd1);
            chk("solo_id", 32'(s_id), 32'd3);
            if (i > 0) chk("solo_grant", 32'(s_grant), 32'd3);
        end
        cycle(4'hF, 4'hF, 1'b1, 1'b0, g, x);
        chk("after_solo_id", 32'(s_id), 32'd0);

        // Random traffic; a requester keeps VALID/LAST until it is accepted.
        v = '0; l = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(v[i] && !(x && g == i))) begin
                    v[i] = 1'($urandom_range(0, 1));
                    l[i] = ($urandom_range(0, 9) < 4);
                end
            end
            r = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 199) == 0);
            cycle(v, l, r, s, g, x);
            if (s) v = '0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
